// File: rtl/seq_chunk_subtractor.sv
// seq_chunk_subtractor: computes diff = in1 - in2 - bin one CHUNK-bit slice
// per clock, LSB slice first, rippling the borrow through a register.
//
// Handshake: start is a request sampled only while idle (busy=0); the edge
// that samples start=1 latches in1/in2/bin and the operation is then owned by
// the block. done is a single-cycle completion pulse; diff/bout/ovf are valid
// from that cycle until the next accepted start. start while busy=1 is
// dropped, never queued.
module seq_chunk_subtractor #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic [1:0]   state_dbg
);

    localparam int K    = N / CHUNK;
    localparam int IDXW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [N-1:0]      a_q;
    logic [N-1:0]      b_q;
    logic [N-1:0]      diff_q;
    logic              borrow_q;
    logic [IDXW-1:0]   idx_q;
    logic              bout_q;
    logic              ovf_q;

    logic [31:0]       base;
    logic [CHUNK-1:0]  a_sl;
    logic [CHUNK-1:0]  b_sl;
    logic [CHUNK-1:0]  d_sl;
    logic [CHUNK:0]    sum;
    logic              last;

    // Current slice: a + ~b + ~borrow; the carry out is the inverted borrow.
    always_comb begin
        base = 32'(idx_q) * 32'(CHUNK);
        a_sl = a_q[base +: CHUNK];
        b_sl = b_q[base +: CHUNK];
        sum  = {1'b0, a_sl} + {1'b0, ~b_sl} + {{CHUNK{1'b0}}, ~borrow_q};
        d_sl = sum[CHUNK-1:0];
        last = (idx_q == IDXW'(K - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: accept in IDLE, run K slices, one DONE cycle, back to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then write one diff slice per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= in1;
                        b_q      <= in2;
                        borrow_q <= bin;
                        idx_q    <= '0;
                        diff_q   <= '0;
                        bout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                RUN: begin
                    diff_q[base +: CHUNK] <= d_sl;
                    borrow_q              <= ~sum[CHUNK];
                    if (last) begin
                        idx_q  <= '0;
                        bout_q <= ~sum[CHUNK];
                        // The top slice's MSB is the result sign bit.
                        ovf_q  <= (a_q[N-1] != b_q[N-1]) && (d_sl[CHUNK-1] != a_q[N-1]);
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_chunk_subtractor.sv
// Bench for seq_chunk_subtractor: directed and random operations checked
// against a plain-arithmetic reference model.
module tb_seq_chunk_subtractor;

    localparam int N     = 32;
    localparam int CHUNK = 8;
    localparam int K     = N / CHUNK;
    localparam int W     = N + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] in1 = '0;
    logic [N-1:0] in2 = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    logic [1:0]   state_dbg;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    seq_chunk_subtractor #(.N(N), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in1       (in1),
        .in2       (in2),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Reference model: {ovf, bout, diff} from integer arithmetic.
    function automatic logic [W-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic b);
        longint ux, uy, sx, sy, bb, ud, sd;
        logic [63:0] raw;
        logic m_bout, m_ovf;
        ux = x;
        uy = y;
        sx = $signed(x);
        sy = $signed(y);
        bb = b;
        ud = ux - uy - bb;
        sd = sx - sy - bb;
        raw = ud;
        m_bout = (ud < 0);
        m_ovf  = (sd > ((longint'(1) <<< (N - 1)) - 1)) || (sd < -(longint'(1) <<< (N - 1)));
        return {m_ovf, m_bout, raw[N-1:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Driver: one full operation with cycle-by-cycle checks of busy/done/diff.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic b);
        logic [W-1:0] e;
        logic [N-1:0] mask;
        int done_cnt, busy_cnt, done_at;
        e = model(x, y, b);
        done_cnt = 0;
        busy_cnt = 0;
        done_at = -1;
        @(negedge clk);
        in1 = x; in2 = y; bin = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in1 = $urandom; in2 = $urandom; bin = 1'($urandom_range(0, 1));
        for (int i = 1; i <= K + 3; i++) begin
            if (i > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            if (i <= K) begin
                mask = (i == 1) ? '0 : ((N'(1) << ((i - 1) * CHUNK)) - N'(1));
                check("partial_diff", 64'(diff), 64'(e[N-1:0] & mask));
            end
            if (i == K + 1) begin
                check("diff", 64'(diff), 64'(e[N-1:0]));
                check("bout", 64'(bout), 64'(e[N]));
                check("ovf", 64'(ovf), 64'(e[N+1]));
            end
            if (i == K + 3) check("diff_held", 64'(diff), 64'(e[N-1:0]));
        end
        check("busy_cycles", 64'(busy_cnt), 64'(K + 1));
        check("done_count", 64'(done_cnt), 64'(1));
        check("done_latency", 64'(done_at), 64'(K + 1));
    endtask

    // Scoreboard pop on an observed done pulse.
    task automatic pop_check();
        logic [W-1:0] e;
        check("pulse_done_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pulse_result", 64'({ovf, bout, diff}), 64'(e));
        end
    endtask

    initial begin
        int next_ok;
        int acc;
        int dones;
        int late_done;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_diff", 64'(diff), 64'(0));
        check("rst_bout", 64'(bout), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(32'h0000_000A, 32'h0000_0003, 1'b0);
        check("dir1_diff", 64'(diff), 64'(32'h0000_0007));
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0);
        check("dir2_diff", 64'(diff), 64'(32'hFFFF_FFFF));
        check("dir2_bout", 64'(bout), 64'(1));
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0);
        check("dir3_diff", 64'(diff), 64'(32'h7FFF_FFFF));
        check("dir3_ovf", 64'(ovf), 64'(1));
        check("dir3_bout", 64'(bout), 64'(0));
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1);
        check("dir4_diff", 64'(diff), 64'(32'hFFFF_FFFF));
        check("dir4_bout", 64'(bout), 64'(1));
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Random operations
        for (int r = 0; r < 12; r++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        // start held high every cycle with changing operands
        next_ok = 0;
        acc = 0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            in1 = $urandom;
            in2 = $urandom;
            bin = 1'($urandom_range(0, 1));
            start = 1'b1;
            if (c >= next_ok) begin
                exp_q.push_back(model(in1, in2, bin));
                acc++;
                next_ok = c + K + 2;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dones++;
                pop_check();
            end
        end
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                pop_check();
            end
        end
        check("pulse_accepted", 64'(dones), 64'(4));
        check("pulse_drained", 64'(exp_q.size()), 64'(0));

        // Reset during the second RUN cycle
        @(negedge clk);
        in1 = 32'hFFFF_FFFF; in2 = 32'h0; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_diff", 64'(diff), 64'(0));
        check("midrst_bout", 64'(bout), 64'(0));
        check("midrst_ovf", 64'(ovf), 64'(0));
        late_done = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) late_done++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < K + 2; c++) begin
            @(negedge clk);
            if (done) late_done++;
        end
        check("midrst_no_done", 64'(late_done), 64'(0));
        run_op(32'd5, 32'd9, 1'b0);
        check("post_rst_diff", 64'(diff), 64'(32'hFFFF_FFFC));
        check("post_rst_bout", 64'(bout), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_chunk_subtractor.md
Name: seq_chunk_subtractor

Overview:
- Multi-cycle subtractor; the inverse-operation companion to the team's carry-increment adder.
- Computes diff = in1 - in2 - bin over N/CHUNK clock cycles, one CHUNK-bit slice per cycle, LSB slice first.
- Borrow ripples between slices through a register.
- Used where a full-width combinational borrow chain does not meet timing. Start/done handshake toward the datapath controller.

Parameters:
- N, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, slice width processed per cycle; K = N/CHUNK slices (K >= 1).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- in1  input  N  minuend; sampled with start.
- in2  input  N  subtrahend; sampled with start.
- bin  input  1  borrow-in; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- diff  output  N  result; held until the next accepted start.
- bout  output  1  borrow-out; 1 when the unsigned in1 < in2 + bin.
- ovf  output  1  signed (two's-complement) overflow of in1 - in2 - bin.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
  - Operand registers, borrow register and slice index cleared.
  - Reset mid-RUN aborts the operation; no done pulse is ever produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On a clock edge with start=1: latch in1, in2 and bin; borrow_reg=bin; idx=0.
  - In the same edge: clear diff, bout and ovf to 0; go to RUN.
  - start=0: stay in IDLE.
- RUN: each edge processes slice idx.
  - Let a = in1 slice idx, b = in2 slice idx.
  - Compute {c, d} = a + ~b + ~borrow_reg, a (CHUNK+1)-bit sum.
  - Write d into diff slice idx; borrow_reg = ~c; idx = idx+1.
  - Slices not yet processed read 0 in diff.
  - When idx == K-1 is processed:
    - bout = ~c of that slice.
    - ovf = (in1[N-1] != in2[N-1]) && (d[CHUNK-1] != in1[N-1]).
    - done=1; go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge: done=0; go to IDLE.
  - start is ignored in DONE and not queued.
- Latency:
  - Start sampled at edge T; done high during the cycle following edge T+K.
  - Next start is accepted at edge T+K+2 at the earliest.
  - Throughput: one operation per K+2 cycles.
- start while busy=1: ignored. Operand changes while busy have no effect (latched copies are used).
- diff, bout and ovf are stable from the DONE cycle until the next accepted start.
- K=1 (CHUNK=N): a single RUN cycle; the same rules apply.
- Arithmetic wraps modulo 2^N.
- bin=1 with in1=in2 gives diff = all ones and bout=1.

Test Plan (N=32, CHUNK=8, K=4):
- Reset, then start with in1=0x0000_000A, in2=0x0000_0003, bin=0:
  - done pulses for exactly 1 cycle, 4 edges after start.
  - diff=0x0000_0007, bout=0, ovf=0.
  - busy high for 5 cycles.
- Borrow across all slices: in1=0x0000_0000, in2=0x0000_0001, bin=0:
  - diff=0xFFFF_FFFF, bout=1, ovf=0.
- Signed overflow: in1=0x8000_0000, in2=0x0000_0001, bin=0:
  - diff=0x7FFF_FFFF, ovf=1, bout=0.
- Borrow-in: in1=0x1234_5678, in2=0x1234_5678, bin=1:
  - diff=0xFFFF_FFFF, bout=1, ovf=0.
- start pulsed on every cycle with changing operands for 20 cycles:
  - only starts sampled in IDLE are accepted (one per 6 cycles).
  - each result matches the operands latched at its start.
- Assert rst_n=0 during the 2nd RUN cycle:
  - outputs go to 0 immediately; no done pulse.
  - a following start with in1=5, in2=9 gives diff=0xFFFF_FFFC, bout=1.
